// File: rtl/shared_reg_responder_if.sv
// shared_reg_responder_if: request/response bus between the memory manager and the register responder
interface shared_reg_responder_if;
  logic        req_valid;
  logic        rdwr_cntl;
  logic [27:0] mm_address;
  logic [31:0] write_data;
  logic        busy;
  logic        read_user_data_available;
  logic [31:0] read_user_buffer_output_data;
  logic        write_control_done;
  logic        addr_error;
  modport master (
    output req_valid, rdwr_cntl, mm_address, write_data,
    input  busy, read_user_data_available, read_user_buffer_output_data, write_control_done, addr_error
  );
  modport slave (
    input  req_valid, rdwr_cntl, mm_address, write_data,
    output busy, read_user_data_available, read_user_buffer_output_data, write_control_done, addr_error
  );
endinterface

// File: rtl/shared_reg_responder.sv
// shared_reg_responder: word-addressed register file answering single-word shared-memory requests
module shared_reg_responder #(
  parameter logic [27:0] BASE_ADDR = 28'h8000000,
  parameter int NUM_WORDS = 32,
  parameter int READ_LATENCY = 2,
  localparam int AW = $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_reg_responder_if.slave bus,
  input  logic                 host_we,
  input  logic [AW-1:0]        host_addr,
  input  logic [31:0]          host_wdata,
  output logic [31:0]          host_rdata,
  output logic                 host_conflict,
  output logic [31:0]          atom_flag
);
  localparam logic [27:0] SPAN = 28'(4 * NUM_WORDS);
  typedef enum logic [2:0] {IDLE, READ_WAIT, READ_DONE, WRITE_DONE, ERR_DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic wr_q, ok, accept, iwr, capture, same_word;
  logic [AW-1:0] idx, idx_q;
  logic [27:0] off;
  logic [31:0] rdata;
  logic [31:0] mem [NUM_WORDS];
  assign off = bus.mm_address - BASE_ADDR;
  assign ok = bus.mm_address[1:0] == 2'b00 && bus.mm_address >= BASE_ADDR && off < SPAN;
  assign idx = off[AW+1:2];
  assign accept = state == IDLE && bus.req_valid;
  assign iwr = accept && ok && bus.rdwr_cntl;
  assign same_word = iwr && host_addr == idx;
  assign capture = state != READ_DONE && state_nx == READ_DONE;
  assign atom_flag = mem[0];
  assign bus.read_user_buffer_output_data = rdata;
  always_comb begin
    state_nx = IDLE;
    bus.busy = state != IDLE;
    bus.read_user_data_available = state == READ_DONE || (state == ERR_DONE && !wr_q);
    bus.write_control_done = state == WRITE_DONE || (state == ERR_DONE && wr_q);
    bus.addr_error = state == ERR_DONE;
    if (state == IDLE)
      state_nx = !bus.req_valid ? IDLE : !ok ? ERR_DONE : bus.rdwr_cntl ? WRITE_DONE :
                 READ_LATENCY == 1 ? READ_DONE : READ_WAIT;
    else if (state == READ_WAIT)
      state_nx = cnt == 4'd1 ? READ_DONE : READ_WAIT;
  end
  // initiator write beats a host write to the same word on the same edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      rdata <= '0;
      host_rdata <= '0;
      host_conflict <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept) cnt <= 4'(READ_LATENCY - 1);
      else if (state == READ_WAIT) cnt <= cnt - 4'd1;
      if (accept) begin
        wr_q <= bus.rdwr_cntl;
        idx_q <= idx;
      end
      if (capture) rdata <= mem[state == IDLE ? idx : idx_q];
      if (accept && !ok && !bus.rdwr_cntl) rdata <= 32'hDEADBEEF;
      host_rdata <= mem[host_addr];
      host_conflict <= host_we && same_word;
      if (host_we && !same_word) mem[host_addr] <= host_wdata;
      if (iwr) mem[idx] <= bus.write_data;
    end
endmodule

// File: tb/tb_shared_reg_responder.sv
// tb_shared_reg_responder: directed requests checked every cycle against a latency/array model
module tb_shared_reg_responder;
  localparam logic [27:0] BASE = 28'h8000000;
  localparam int RL = 2;
  logic clk = 1'b0, reset = 1'b0, host_we = 1'b0, host_conflict;
  logic [4:0] host_addr = '0;
  logic [31:0] host_wdata = '0, host_rdata, atom_flag;
  int tests = 0, fails = 0;

  shared_reg_responder_if bus();
  shared_reg_responder dut (
    .clk(clk), .reset(reset), .bus(bus),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_conflict(host_conflict), .atom_flag(atom_flag)
  );

  always #5 clk = ~clk;

  // model: word array plus a countdown of edges until the completion pulse
  logic [31:0] m_mem [32];
  int left = 0;
  logic t_ok = 1'b0, t_rd = 1'b0, m_acc, m_pulse, m_iw;
  logic [4:0] t_idx = '0;
  logic [27:0] m_off;
  logic e_busy = 1'b0, e_rda = 1'b0, e_wcd = 1'b0, e_err = 1'b0, e_conf = 1'b0;
  logic [31:0] e_rdata = '0, e_hrd = '0, e_atom = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      left = 0;
      {e_busy, e_rda, e_wcd, e_err, e_conf} = '0;
      {e_rdata, e_hrd, e_atom} = '0;
    end else begin
      m_acc = !e_busy && bus.req_valid;
      m_pulse = 1'b0;
      {e_rda, e_wcd, e_err, e_busy} = '0;
      e_hrd = m_mem[host_addr];
      if (left > 0) begin
        e_busy = 1'b1;
        left--;
        m_pulse = left == 0;
      end
      if (m_acc) begin
        m_off = bus.mm_address - BASE;
        t_ok = bus.mm_address[1:0] == 2'b00 && bus.mm_address >= BASE && m_off < 28'd128;
        t_rd = !bus.rdwr_cntl;
        t_idx = m_off[6:2];
        left = (t_ok && t_rd) ? RL - 1 : 0;
        m_pulse = left == 0;
        e_busy = 1'b1;
      end
      if (m_pulse) begin
        e_err = !t_ok;
        e_rda = t_rd;
        e_wcd = !t_rd;
        if (t_rd) e_rdata = t_ok ? m_mem[t_idx] : 32'hDEADBEEF;
      end
      m_iw = m_acc && t_ok && !t_rd;
      e_conf = host_we && m_iw && host_addr == t_idx;
      if (host_we && !e_conf) m_mem[host_addr] = host_wdata;
      if (m_iw) m_mem[t_idx] = bus.write_data;
      e_atom = m_mem[0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("data_available", 32'(bus.read_user_data_available), 32'(e_rda));
    chk("write_done", 32'(bus.write_control_done), 32'(e_wcd));
    chk("addr_error", 32'(bus.addr_error), 32'(e_err));
    chk("read_data", bus.read_user_buffer_output_data, e_rdata);
    chk("host_rdata", host_rdata, e_hrd);
    chk("host_conflict", 32'(host_conflict), 32'(e_conf));
    chk("atom_flag", atom_flag, e_atom);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic host_write(input int i, input logic [31:0] d);
    host_we = 1'b1;
    host_addr = 5'(i);
    host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_read(input int i, output logic [31:0] q);
    host_addr = 5'(i);
    tick();
    q = host_rdata;
  endtask

  // n = cycles between the one after acceptance and the completion pulse
  task automatic request(input logic rw, input logic [27:0] a, input logic [31:0] d,
                         output int n, output logic [31:0] q, output logic rd, output logic wd, output logic er);
    int g = 0;
    while (bus.busy && g < 20) begin tick(); g++; end
    if (bus.busy) chk("idle_timeout", 32'(bus.busy), 32'd0);
    bus.req_valid = 1'b1;
    bus.rdwr_cntl = rw;
    bus.mm_address = a;
    bus.write_data = d;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!(bus.read_user_data_available || bus.write_control_done) && n < 20) begin tick(); n++; end
    q = bus.read_user_buffer_output_data;
    rd = bus.read_user_data_available;
    wd = bus.write_control_done;
    er = bus.addr_error;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] q;
    logic rd, wd, er, seen;
    bus.req_valid = 1'b0;
    bus.rdwr_cntl = 1'b0;
    bus.mm_address = '0;
    bus.write_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_atom", atom_flag, 32'd0);
    chk("reset_data", bus.read_user_buffer_output_data, 32'd0);
    reset = 1'b1;
    tick();
    host_write(0, 32'hAAAA0000);
    request(1'b0, BASE, 32'd0, n, q, rd, wd, er);
    chk("rd0_latency", n, 1);
    chk("rd0_data", q, 32'hAAAA0000);
    chk("rd0_avail", 32'(rd), 32'd1);
    chk("rd0_err", 32'(er), 32'd0);
    chk("model_rd0", e_rdata, 32'hAAAA0000);
    chk("atom_after_host", atom_flag, 32'hAAAA0000);
    request(1'b1, BASE + 28'd4, 32'h00000001, n, q, rd, wd, er);
    chk("wr1_latency", n, 0);
    chk("wr1_done", 32'(wd), 32'd1);
    chk("wr1_avail", 32'(rd), 32'd0);
    host_read(1, q);
    chk("wr1_host_read", q, 32'h00000001);
    for (int i = 2; i < 26; i++) host_write(i, 32'h100 + 32'(i));
    for (int i = 2; i < 26; i++) begin
      request(1'b0, BASE + 28'(4 * i), 32'd0, n, q, rd, wd, er);
      chk($sformatf("blk_latency%0d", i), n, 1);
      chk($sformatf("blk_data%0d", i), q, 32'h100 + 32'(i));
    end
    host_write(31, 32'hCAFE0031);
    request(1'b0, BASE + 28'h7C, 32'd0, n, q, rd, wd, er);
    chk("top_word_data", q, 32'hCAFE0031);
    chk("top_word_err", 32'(er), 32'd0);
    request(1'b0, 28'h8000080, 32'd0, n, q, rd, wd, er);
    chk("oob_rd_err", 32'(er), 32'd1);
    chk("oob_rd_avail", 32'(rd), 32'd1);
    chk("oob_rd_data", q, 32'hDEADBEEF);
    chk("oob_rd_latency", n, 0);
    chk("model_oob", e_rdata, 32'hDEADBEEF);
    request(1'b0, 28'h8000006, 32'd0, n, q, rd, wd, er);
    chk("misaligned_err", 32'(er), 32'd1);
    chk("misaligned_data", q, 32'hDEADBEEF);
    request(1'b0, 28'h7FFFFFC, 32'd0, n, q, rd, wd, er);
    chk("below_base_err", 32'(er), 32'd1);
    request(1'b1, 28'h8000080, 32'h00000055, n, q, rd, wd, er);
    chk("oob_wr_err", 32'(er), 32'd1);
    chk("oob_wr_done", 32'(wd), 32'd1);
    chk("oob_wr_avail", 32'(rd), 32'd0);
    chk("oob_wr_data_held", bus.read_user_buffer_output_data, 32'hDEADBEEF);
    host_read(0, q);
    chk("oob_wr_word0", q, 32'hAAAA0000);
    host_we = 1'b1;
    host_addr = 5'd3;
    host_wdata = 32'h1111;
    bus.req_valid = 1'b1;
    bus.rdwr_cntl = 1'b1;
    bus.mm_address = BASE + 28'hC;
    bus.write_data = 32'h2222;
    tick();
    host_we = 1'b0;
    bus.req_valid = 1'b0;
    chk("conflict_pulse", 32'(host_conflict), 32'd1);
    chk("conflict_wdone", 32'(bus.write_control_done), 32'd1);
    tick();
    chk("conflict_once", 32'(host_conflict), 32'd0);
    host_read(3, q);
    chk("conflict_word3", q, 32'h2222);
    host_we = 1'b1;
    host_addr = 5'd4;
    host_wdata = 32'h4444;
    bus.req_valid = 1'b1;
    bus.mm_address = BASE + 28'h14;
    bus.write_data = 32'h5555;
    tick();
    host_we = 1'b0;
    bus.req_valid = 1'b0;
    chk("split_no_conflict", 32'(host_conflict), 32'd0);
    tick();
    host_read(4, q);
    chk("split_word4", q, 32'h4444);
    host_read(5, q);
    chk("split_word5", q, 32'h5555);
    bus.req_valid = 1'b1;
    bus.rdwr_cntl = 1'b0;
    bus.mm_address = BASE + 28'h8;
    tick();
    bus.req_valid = 1'b0;
    chk("mid_read_busy", 32'(bus.busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_avail", 32'(bus.read_user_data_available), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen |= bus.read_user_data_available;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    for (int i = 0; i < 32; i++) begin
      host_read(i, q);
      chk($sformatf("cleared_word%0d", i), q, 32'd0);
    end
    chk("cleared_atom", atom_flag, 32'd0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
